// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// Execute-stage ALU with valid/ready handshakes: single-cycle arithmetic, shift,
// half-load and compare ops, plus iterative unsigned multiply and divide.
module alu_seq #(
    parameter int WIDTH      = 64,
    parameter bit SHIFT_FILL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag,
    output logic             carry,
    output logic             err
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] FILL    = SHIFT_FILL ? ONES : '0;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] c_res;
    logic             c_flag;
    logic             c_carry;
    logic             c_err;
    logic [WIDTH:0]   sum_ext;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: every output of a combinational block gets a default first, otherwise
    // the paths that skip an assignment infer latches.
    always_comb begin
        c_res   = '0;
        c_flag  = 1'b0;
        c_carry = 1'b0;
        c_err   = 1'b0;
        sum_ext = '0;
        case (op)
            6'd0: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                c_res   = sum_ext[WIDTH-1:0];
                c_carry = sum_ext[WIDTH];
            end
            6'd1: begin
                sum_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                c_res   = sum_ext[WIDTH-1:0];
                c_carry = sum_ext[WIDTH];
            end
            6'd2: c_res = (b >= WIDTH_V) ? FILL : ((a << b) | (FILL & ~(ONES << b)));
            6'd3: c_res = (b >= WIDTH_V) ? FILL : ((a >> b) | (FILL & ~(ONES >> b)));
            6'd4: c_res = a;
            6'd5: c_res = hl ? {b[HALF-1:0], a[HALF-1:0]} : {a[WIDTH-1:HALF], b[HALF-1:0]};
            6'd8:  c_flag = (a == b);
            6'd9:  c_flag = (a < b);
            6'd10: c_flag = (a > b);
            6'd16, 6'd17: ;
            default: c_err = 1'b1;
        endcase
    end

    // Multiply: acc_hi is the running upper half, acc_lo holds the unconsumed
    // multiplier bits and collects product bits shifted out of acc_hi.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and
    // quotient bits in. A zero divisor naturally yields all-ones and remainder a.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_rem;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result    <= '0;
            result_hi <= '0;
            flag      <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        if (op == 6'd16) begin
                            opnd   <= a;
                            acc_hi <= '0;
                            acc_lo <= b;
                            state  <= MUL;
                        end else if (op == 6'd17) begin
                            opnd   <= b;
                            acc_hi <= '0;
                            acc_lo <= a;
                            state  <= DIV;
                        end else begin
                            result    <= c_res;
                            result_hi <= '0;
                            flag      <= c_flag;
                            carry     <= c_carry;
                            err       <= c_err;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        result_hi <= mul_sum[WIDTH:1];
                        flag      <= 1'b0;
                        carry     <= 1'b0;
                        err       <= 1'b0;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    acc_hi <= div_rem;
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= {acc_lo[WIDTH-2:0], div_ge};
                        result_hi <= div_rem;
                        flag      <= 1'b0;
                        carry     <= 1'b0;
                        err       <= (opnd == '0);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the core single-cycle 64-bit ALU. It executes the same 6-bit opcode set (add/sub, shifts, pass, half-load, compare flags) and adds iterative unsigned multiply and divide that produce full double-width / remainder results. Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on long operations. It sits in the execute stage between register read and writeback.

## Interface
- WIDTH, 64: operand/result width; even, ≥ 8.
- SHIFT_FILL, 1: bit value shifted into vacated positions by opcodes 2/3 (1 = ones-fill, the existing core behaviour).
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  6  opcode.
- a, b  in  WIDTH  operands.
- hl  in  1  half select for opcode 5.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  product high half (op 16) / remainder (op 17); 0 otherwise.
- flag  out  1  compare result (ops 8–10); 0 otherwise.
- carry  out  1  carry-out of op 0, not-borrow of op 1; 0 otherwise.
- err  out  1  divide by zero or unknown opcode.

## Operation
- Opcodes: 0 a+b; 1 a−b (a + ~b + 1); 2 a<<b; 3 a>>b; 4 pass a; 5 half-load: hl=0 → {a[W-1:W/2], b[W/2-1:0]}, hl=1 → {b[W/2-1:0], a[W/2-1:0]}; 8 flag=(a==b); 9 flag=(a<b) unsigned; 10 flag=(a>b) unsigned; 16 unsigned a*b → {result_hi,result}; 17 unsigned a/b → result=quotient, result_hi=remainder.
- Shifts: vacated bits = SHIFT_FILL; b ≥ WIDTH → result = {WIDTH{SHIFT_FILL}}.
- Compare ops: result = 0.
- Any other opcode: result = 0, result_hi = 0, flag = 0, err = 1.
- Divide by zero: result = all ones, result_hi = a, err = 1; still takes the full divide latency.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On accept (in_valid & in_ready): op 16 → MUL, op 17 → DIV, else compute and register outputs → DONE.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, counter 0..WIDTH-1; after the last iteration → DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations → DONE.
  - DONE: out_valid=1, outputs stable; out_ready=1 → IDLE.
- Operands are captured at accept; later changes on a/b/op/hl have no effect.
- in_ready is 0 in MUL, DIV and DONE; no accept occurs in the cycle a result drains.

## Timing
- Reset (asynchronous, any state, including mid-MUL/DIV): state=IDLE; in_ready=1; out_valid, result, result_hi, flag, carry, err = 0; iteration counter and partial product/remainder cleared; any in-flight operation is discarded.
- Single-cycle ops: accept at edge E0 → out_valid=1 from E0 until the drain edge.
- Mul/div: accept at E0 → out_valid=1 after edge E0+WIDTH.
- Drain: out_valid & out_ready at edge Ed → out_valid=0 and in_ready=1 after Ed. Earliest next accept is Ed+1, so single-cycle throughput is one op per 2 cycles.
- Outputs hold their values while out_valid=1 & out_ready=0 (indefinite stall).
- result, result_hi, flag, carry, err are undefined-but-stable when out_valid=0; the bench checks them only with out_valid=1.

## Test plan
- WIDTH=64, op0 a=FFFF_FFFF_FFFF_FFFF b=1 → result=0, carry=1; op1 a=5 b=7 → result=FFFF_FFFF_FFFF_FFFE, carry=0; both with out_valid exactly 1 cycle after accept.
- op2 a=1 b=4, SHIFT_FILL=1 → result=0x1F; op3 a=0 b=64 → all ones; op5 hl=1 a=0x1111_2222_3333_4444 b=0xAAAA_BBBB → 0xAAAA_BBBB_3333_4444.
- op16 a=FFFF_FFFF_FFFF_FFFF b=2 → result_hi=1, result=FFFF_FFFF_FFFF_FFFE; out_valid after exactly 64 cycles; in_ready=0 throughout.
- op17 a=100 b=7 → result=14, result_hi=2, err=0; op17 b=0 a=9 → result=all ones, result_hi=9, err=1.
- Hold out_ready=0 for 10 cycles after op9 a=3 b=4 → flag=1 held stable and in_ready=0 throughout; raise out_ready → idle next cycle.
- Assert reset_n=0 at iteration 30 of a divide → all outputs 0 immediately; after release, op0 a=2 b=3 → 5 with no residue of the aborted divide.
